// File: rtl/lab_adder_pkg.sv
// Shared types and constants for the sliced add/subtract unit.
// Holds the FSM encoding and default operand geometry.
package lab_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SLICE = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple-carry chain of fulladder cells.
// Also exposes the carry into the slice MSB for overflow detection.
module adder_slice #(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [SLICE:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    fulladder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co    = c[SLICE];
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell, the building block of every ripple
// chain in the lab adders.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/seq_slice_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands pass LSB slice first
// through one SLICE-bit ripple slice, with start/busy/done handshake.
module seq_slice_adder
  import lab_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = idx_w(NSLICE);
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last;
  logic [SLICE-1:0] sl_s;
  logic             sl_co;
  logic             sl_cm;
  logic [WIDTH+SLICE-1:0] res_cat;

  adder_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a     (a_q[SLICE-1:0]),
    .b     (b_q[SLICE-1:0]),
    .ci    (carry_q),
    .s     (sl_s),
    .co    (sl_co),
    .c_msb (sl_cm)
  );

  assign accept  = start &&
                   (state_q == ST_IDLE || state_q == ST_DONE);
  assign last    = (idx_q == LAST);
  // New slice enters at the top; after NSLICE shifts it is aligned.
  assign res_cat = {sl_s, res_q};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last)  state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      // Subtract as a + ~b + ~borrow.
      a_d     = a;
      b_d     = b ^ {WIDTH{sub}};
      carry_d = cin ^ sub;
      idx_d   = '0;
      res_d   = '0;
    end else if (state_q == ST_RUN) begin
      a_d     = a_q >> SLICE;
      b_d     = b_q >> SLICE;
      res_d   = res_cat[WIDTH+SLICE-1:SLICE];
      carry_d = sl_co;
      idx_d   = idx_q + 1'b1;
      if (last) begin
        sum_d  = res_cat[WIDTH+SLICE-1:SLICE];
        cout_d = sl_co;
        ovf_d  = sl_co ^ sl_cm;
      end
    end
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
    sum  = sum_q;
    cout = cout_q;
    ovf  = ovf_q;
  end

endmodule

// File: tb/tb_seq_slice_adder.sv
// Scoreboard bench for seq_slice_adder in 8/2, 8/8 and 12/3 builds.
// Expected results are queued at issue and popped on done.
module tb_seq_slice_adder;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [11:0] sum;
  } exp_t;

  logic clk;
  logic resetn;
  int   cyc;
  int   pass_cnt;
  int   chk_cnt;
  int   dcnt0;

  logic       start0, sub0, cin0;
  logic [7:0] a0, b0;
  logic       busy0, done0, cout0, ovf0;
  logic [7:0] sum0;

  logic        startr, subr, cinr;
  logic [11:0] ar, br;
  logic        busy1, done1, cout1, ovf1;
  logic [7:0]  sum1;
  logic        busy2, done2, cout2, ovf2;
  logic [11:0] sum2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  seq_slice_adder #(.WIDTH(8), .SLICE(2)) u0 (
    .clk(clk), .resetn(resetn), .start(start0),
    .sub(sub0), .a(a0), .b(b0), .cin(cin0),
    .busy(busy0), .done(done0), .sum(sum0),
    .cout(cout0), .ovf(ovf0)
  );

  seq_slice_adder #(.WIDTH(8), .SLICE(8)) u1 (
    .clk(clk), .resetn(resetn), .start(startr),
    .sub(subr), .a(ar[7:0]), .b(br[7:0]), .cin(cinr),
    .busy(busy1), .done(done1), .sum(sum1),
    .cout(cout1), .ovf(ovf1)
  );

  seq_slice_adder #(.WIDTH(12), .SLICE(3)) u2 (
    .clk(clk), .resetn(resetn), .start(startr),
    .sub(subr), .a(ar), .b(br), .cin(cinr),
    .busy(busy2), .done(done2), .sum(sum2),
    .cout(cout2), .ovf(ovf2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done0) dcnt0 <= dcnt0 + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  function automatic exp_t model(input int w,
      input logic [11:0] a, input logic [11:0] b,
      input logic c, input logic s);
    longint m, ua, ub, sa, sb, r, sr;
    exp_t e;
    m  = longint'(1) << w;
    ua = longint'(a) % m;
    ub = longint'(b) % m;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!s) begin
      r  = ua + ub + longint'(c);
      sr = sa + sb + longint'(c);
      e.cout = (r >= m);
    end else begin
      r  = ua - ub - longint'(c);
      sr = sa - sb - longint'(c);
      e.cout = (r >= 0);
    end
    e.sum = 12'(((r % m) + m) % m);
    e.ovf = (sr < -(m / 2)) || (sr >= m / 2);
    return e;
  endfunction

  // Call at a negedge; returns just after the accepting edge.
  task automatic issue0(input logic [7:0] a, input logic [7:0] b,
      input logic c, input logic s, input bit push,
      input logic [7:0] es, input logic ec, input logic eo);
    a0 = a; b0 = b; cin0 = c; sub0 = s;
    start0 = 1'b1;
    if (push) q0.push_back({eo, ec, 4'h0, es});
    @(posedge clk);
    #1;
    start0 = 1'b0;
    a0 = 8'($urandom); b0 = 8'($urandom);
    cin0 = 1'($urandom); sub0 = 1'($urandom);
  endtask

  task automatic wait_done0(output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy0) bc++;
      if (done0) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if ({busy0, done0, cout0, ovf0, sum0} !== 12'h0)
      $display("FAIL reset_u0: got %h want 000",
               {busy0, done0, cout0, ovf0, sum0});
    else pass_cnt++;
    chk_cnt++;
    if ({busy1, done1, cout1, ovf1, sum1,
         busy2, done2, cout2, ovf2, sum2} !== 28'h0)
      $display("FAIL reset_u1u2: got %h want 0",
               {busy1, done1, cout1, ovf1, sum1,
                busy2, done2, cout2, ovf2, sum2});
    else pass_cnt++;
    resetn = 1'b1;
  endtask

  task automatic test_add;
    logic [7:0] ta[3] = '{8'h5A, 8'hFF, 8'h00};
    logic [7:0] tb[3] = '{8'h3C, 8'h01, 8'h00};
    logic       tc[3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] ts[3] = '{8'h96, 8'h00, 8'h01};
    logic       to[3] = '{1'b0, 1'b1, 1'b0};
    logic       tv[3] = '{1'b1, 1'b0, 1'b0};
    int lat, bc;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      issue0(ta[i], tb[i], tc[i], 1'b0, 1'b1,
             ts[i], to[i], tv[i]);
      wait_done0(lat, bc);
      chk_cnt++;
      if (lat !== 4)
        $display("FAIL add_latency[%0d]: got %0d want 4", i, lat);
      else pass_cnt++;
      chk_cnt++;
      if (bc !== 4)
        $display("FAIL add_busy[%0d]: got %0d want 4", i, bc);
      else pass_cnt++;
      chk_cnt++;
      if (q0.size() == 0) begin
        $display("FAIL add_result[%0d]: got done want none", i);
      end else begin
        e = q0.pop_front();
        if ({ovf0, cout0, 4'h0, sum0} !== e)
          $display("FAIL add_result[%0d]: got %h want %h", i,
                   {ovf0, cout0, 4'h0, sum0}, e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_sub;
    logic [7:0] ta[3] = '{8'h10, 8'h80, 8'h05};
    logic [7:0] tb[3] = '{8'h20, 8'h01, 8'h02};
    logic       tc[3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] ts[3] = '{8'hF0, 8'h7F, 8'h02};
    logic       to[3] = '{1'b0, 1'b1, 1'b1};
    logic       tv[3] = '{1'b0, 1'b1, 1'b0};
    int lat, bc;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      issue0(ta[i], tb[i], tc[i], 1'b1, 1'b1,
             ts[i], to[i], tv[i]);
      wait_done0(lat, bc);
      chk_cnt++;
      if (lat !== 4)
        $display("FAIL sub_latency[%0d]: got %0d want 4", i, lat);
      else pass_cnt++;
      chk_cnt++;
      if (q0.size() == 0) begin
        $display("FAIL sub_result[%0d]: got done want none", i);
      end else begin
        e = q0.pop_front();
        if ({ovf0, cout0, 4'h0, sum0} !== e)
          $display("FAIL sub_result[%0d]: got %h want %h", i,
                   {ovf0, cout0, 4'h0, sum0}, e);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_ignore_start;
    int lat, extra;
    exp_t e;
    @(negedge clk);
    issue0(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0, 1'b1);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 2) begin
        start0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF; sub0 = 1'b1;
      end
      if (k == 3) start0 = 1'b0;
      if (done0) begin
        lat = k - 1;
        break;
      end
    end
    chk_cnt++;
    if (lat !== 4)
      $display("FAIL ignore_latency: got %0d want 4", lat);
    else pass_cnt++;
    chk_cnt++;
    if (q0.size() == 0) begin
      $display("FAIL ignore_result: got done want none");
    end else begin
      e = q0.pop_front();
      if ({ovf0, cout0, 4'h0, sum0} !== e)
        $display("FAIL ignore_result: got %h want %h",
                 {ovf0, cout0, 4'h0, sum0}, e);
      else pass_cnt++;
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy0 || done0) extra++;
    end
    chk_cnt++;
    if (extra !== 0)
      $display("FAIL ignore_queued: got %0d active want 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat, bc, t1, t2;
    exp_t e;
    @(negedge clk);
    issue0(8'h33, 8'h11, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0);
    wait_done0(lat, bc);
    t1 = cyc;
    chk_cnt++;
    if (q0.size() == 0) begin
      $display("FAIL b2b_first: got done want none");
    end else begin
      e = q0.pop_front();
      if ({ovf0, cout0, 4'h0, sum0} !== e)
        $display("FAIL b2b_first: got %h want %h",
                 {ovf0, cout0, 4'h0, sum0}, e);
      else pass_cnt++;
    end
    issue0(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
    wait_done0(lat, bc);
    t2 = cyc;
    chk_cnt++;
    if (lat < 0 || t2 - t1 !== 5)
      $display("FAIL b2b_gap: got %0d want 5", t2 - t1);
    else pass_cnt++;
    chk_cnt++;
    if (q0.size() == 0) begin
      $display("FAIL b2b_second: got done want none");
    end else begin
      e = q0.pop_front();
      if ({ovf0, cout0, 4'h0, sum0} !== e)
        $display("FAIL b2b_second: got %h want %h",
                 {ovf0, cout0, 4'h0, sum0}, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, bc, d;
    exp_t e;
    @(negedge clk);
    issue0(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({busy0, done0, cout0, ovf0, sum0} !== 12'h0)
      $display("FAIL midrst_state: got %h want 000",
               {busy0, done0, cout0, ovf0, sum0});
    else pass_cnt++;
    resetn = 1'b1;
    d = dcnt0;
    repeat (8) @(negedge clk);
    chk_cnt++;
    if (dcnt0 !== d || busy0 !== 1'b0)
      $display("FAIL midrst_nodone: got %0d dones busy %b want 0 0",
               dcnt0 - d, busy0);
    else pass_cnt++;
    issue0(8'h03, 8'h04, 1'b0, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0);
    wait_done0(lat, bc);
    chk_cnt++;
    if (lat !== 4)
      $display("FAIL midrst_latency: got %0d want 4", lat);
    else pass_cnt++;
    chk_cnt++;
    if (q0.size() == 0) begin
      $display("FAIL midrst_result: got done want none");
    end else begin
      e = q0.pop_front();
      if ({ovf0, cout0, 4'h0, sum0} !== e)
        $display("FAIL midrst_result: got %h want %h",
                 {ovf0, cout0, 4'h0, sum0}, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_random_sweep;
    int lat1, lat2;
    exp_t e;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      ar   = 12'($urandom);
      br   = 12'($urandom);
      cinr = 1'($urandom);
      subr = 1'($urandom);
      if (n == 0) begin
        ar = 12'h800; br = 12'h001; cinr = 1'b0; subr = 1'b1;
      end
      q1.push_back(model(8, ar, br, cinr, subr));
      q2.push_back(model(12, ar, br, cinr, subr));
      startr = 1'b1;
      @(posedge clk);
      #1;
      startr = 1'b0;
      ar = 12'($urandom); br = 12'($urandom);
      cinr = 1'($urandom); subr = 1'($urandom);
      lat1 = -1;
      lat2 = -1;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (done1) begin
          lat1 = k - 1;
          chk_cnt++;
          if (q1.size() == 0) begin
            $display("FAIL rnd8_result[%0d]: extra done", n);
          end else begin
            e = q1.pop_front();
            if ({ovf1, cout1, 4'h0, sum1} !== e)
              $display("FAIL rnd8_result[%0d]: got %h want %h", n,
                       {ovf1, cout1, 4'h0, sum1}, e);
            else pass_cnt++;
          end
        end
        if (done2) begin
          lat2 = k - 1;
          chk_cnt++;
          if (q2.size() == 0) begin
            $display("FAIL rnd12_result[%0d]: extra done", n);
          end else begin
            e = q2.pop_front();
            if ({ovf2, cout2, sum2} !== e)
              $display("FAIL rnd12_result[%0d]: got %h want %h", n,
                       {ovf2, cout2, sum2}, e);
            else pass_cnt++;
          end
          break;
        end
      end
      chk_cnt++;
      if (lat1 !== 1 || lat2 !== 4)
        $display("FAIL rnd_latency[%0d]: got %0d/%0d want 1/4",
                 n, lat1, lat2);
      else pass_cnt++;
    end
    chk_cnt++;
    if (q1.size() != 0 || q2.size() != 0)
      $display("FAIL rnd_leftover: got %0d/%0d want 0/0",
               q1.size(), q2.size());
    else pass_cnt++;
  endtask

  initial begin
    cyc = 0; dcnt0 = 0; pass_cnt = 0; chk_cnt = 0;
    resetn = 1'b0;
    start0 = 1'b0; sub0 = 1'b0; cin0 = 1'b0;
    a0 = 8'h0; b0 = 8'h0;
    startr = 1'b0; subr = 1'b0; cinr = 1'b0;
    ar = 12'h0; br = 12'h0;
    test_reset;
    test_add;
    test_sub;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid_run;
    test_random_sweep;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
